// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch granularity,
// default reset PC, NOP encoding and the {instr, pc} entry layout.
package fetch_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push/pop/flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; validity is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: in-order requests to a variable-latency imem,
// prefetch FIFO towards decode, redirect flush. Option macro: FETCH_BYPASS_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      drop_cnt;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      pcq_count;
  logic [CNT_W:0]        occupancy;
  logic [ENT_W-1:0]      entry_head;
  logic [ADDR_WIDTH-1:0] pcq_head;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic                  fifo_empty;
  logic                  req_fire;
  logic                  rsp_keep;
  logic                  bypass_take;
  logic                  entry_push;
  logic                  entry_pop;

  assign head_instr = entry_head[ENT_W-1:ADDR_WIDTH];
  assign head_pc    = entry_head[ADDR_WIDTH-1:0];
  assign fifo_empty = (fifo_count == '0);
  assign imem_addr  = fetch_pc;

  // Credit: buffered + live in-flight fetches must never exceed the FIFO capacity.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight} - {1'b0, drop_cnt};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when it belongs to the current stream.
  assign rsp_keep   = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid && (pcq_count != '0);
  assign entry_push = rsp_keep && !bypass_take;
  assign entry_pop  = if_valid && if_ready && !fifo_empty;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    if_valid    = 1'b0;
    if_instr    = '0;
    if_pc       = '0;
    bypass_take = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (fifo_empty && rsp_keep) begin
      if_valid    = 1'b1;
      if_instr    = imem_rsp_data;
      if_pc       = pcq_head;
      bypass_take = if_ready;
    end else if (!redirect_valid && !fifo_empty) begin
      if_valid = 1'b1;
      if_instr = head_instr;
      if_pc    = head_pc;
    end
`else
    if (!redirect_valid && !fifo_empty) begin
      if_valid = 1'b1;
      if_instr = head_instr;
      if_pc    = head_pc;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        // A response landing in the redirect cycle is already stale and not counted.
        drop_cnt <= inflight - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_entry_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (entry_push),
    .push_data ({imem_rsp_data, pcq_head}),
    .pop       (entry_pop),
    .pop_data  (entry_head),
    .count     (fifo_count)
  );

  // PCs of live requests, in issue order; the head tags the next kept response.
  fetch_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .pop_data  (pcq_head),
    .count     (pcq_count)
  );

endmodule
